// File: rtl/tff_bank_counter.sv
// WIDTH-bit bank of toggle cells that runs as per-bit T flip-flops or as a modulo-MOD up/down counter.
// Optional macro TFF_BANK_CNT_SAT_EN makes UP/DOWN saturate at the limits instead of wrapping.
module tff_bank_counter #(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MOD       = 16,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_BANK = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_e;

  // Highest in-range count, truncated to WIDTH bits; for a full binary modulus this is all ones.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             tc_reg;
  logic             tc_next;
  logic [WIDTH-1:0] bank_next;
  logic             over_mod;
  logic             at_max;
  logic             at_zero;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign bank_next[gi] = q_reg[gi] ^ t[gi];
    end
  endgenerate

  assign over_mod = (q_reg > MAX_Q);
  assign at_max   = (q_reg == MAX_Q);
  assign at_zero  = (q_reg == '0);

  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_BANK: q_next = bank_next;
        MODE_UP: begin
          if (over_mod) begin
            q_next = '0;
          end else if (at_max) begin
`ifdef TFF_BANK_CNT_SAT_EN
            q_next = q_reg;
`else
            q_next = '0;
`endif
            tc_next = 1'b1;
          end else begin
            q_next = q_reg + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (over_mod) begin
            q_next = MAX_Q;
          end else if (at_zero) begin
`ifdef TFF_BANK_CNT_SAT_EN
            q_next = q_reg;
`else
            q_next = MAX_Q;
`endif
            tc_next = 1'b1;
          end else begin
            q_next = q_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg  <= RST_Q;
      tc_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      tc_reg <= tc_next;
    end
  end

  assign q    = q_reg;
  assign qbar = ~q_reg;
  assign tc   = tc_reg;

endmodule

// File: tb/tb_tff_bank_counter.sv
// Bench for tff_bank_counter (WIDTH=4, MOD=10): integer reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_tff_bank_counter;

  localparam int W     = 4;
  localparam int MOD_P = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] t;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;

  int n_checks = 0;
  int n_fail   = 0;

  int m_q;
  int m_tc;
  bit sat_build;

  tff_bank_counter #(.WIDTH(W), .MOD(MOD_P), .RESET_VAL(0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t),
    .load(load), .load_val(load_val), .q(q), .qbar(qbar), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count value as a plain integer, rules applied directly.
  always @(posedge clk or negedge reset) begin
    int nq;
    int ntc;
    if (!reset) begin
      m_q  <= 0;
      m_tc <= 0;
    end else begin
      nq  = m_q;
      ntc = 0;
      if (load) begin
        nq = int'(load_val);
      end else if (en && mode == 2'd1) begin
        nq = m_q ^ int'(t);
      end else if (en && mode == 2'd2) begin
        if (m_q >= MOD_P) nq = 0;
        else if (m_q == MOD_P - 1) begin
          nq  = sat_build ? m_q : 0;
          ntc = 1;
        end else nq = m_q + 1;
      end else if (en && mode == 2'd3) begin
        if (m_q >= MOD_P) nq = MOD_P - 1;
        else if (m_q == 0) begin
          nq  = sat_build ? 0 : MOD_P - 1;
          ntc = 1;
        end else nq = m_q - 1;
      end
      m_q  <= nq;
      m_tc <= ntc;
    end
  end

  always @(negedge clk) begin
    check("model_q", int'(q), m_q);
    check("model_qbar", int'(qbar), (~m_q) & 15);
    check("model_tc", int'(tc), m_tc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input string name, input int eq, input int etc);
    check({name, "_q"}, int'(q), eq);
    check({name, "_qbar"}, int'(qbar), (~eq) & 15);
    check({name, "_tc"}, int'(tc), etc);
  endtask

  task automatic do_load(input int v, input logic [1:0] md);
    load = 1'b1; load_val = W'(v); mode = md;
    tick();
    load = 1'b0;
  endtask

  initial begin
`ifdef TFF_BANK_CNT_SAT_EN
    sat_build = 1'b1;
`else
    sat_build = 1'b0;
`endif
    reset = 1'b0; en = 1'b0; mode = 2'd0; t = '0; load = 1'b0; load_val = '0;
    #2;
    expect_q("por", 0, 0);
    tick();
    expect_q("por_held", 0, 0);
    reset = 1'b1;

    // Asynchronous reset mid-cycle from q=7
    do_load(7, 2'd2);
    expect_q("load7", 7, 0);
    #2 reset = 1'b0;
    #1 expect_q("async_rst", 0, 0);
    tick();
    expect_q("rst_held", 0, 0);
    reset = 1'b1;

    // BANK
    do_load(4'b1010, 2'd1);
    en = 1'b1; t = 4'b0110;
    tick(); expect_q("bank1", 4'b1100, 0);
    tick(); expect_q("bank2", 4'b1010, 0);

`ifndef TFF_BANK_CNT_SAT_EN
    // UP wrap, then tc pulses again 10 edges later
    do_load(0, 2'd2);
    for (int i = 1; i <= 10; i++) begin
      tick();
      expect_q($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0);
    end
    for (int i = 11; i <= 20; i++) tick();
    expect_q("up_wrap2", 0, 1);

    // DOWN wrap
    do_load(3, 2'd3);
    tick(); expect_q("dn2", 2, 0);
    tick(); expect_q("dn1", 1, 0);
    tick(); expect_q("dn0", 0, 0);
    tick(); expect_q("dn_wrap", 9, 1);
`else
    en = 1'b1;
    do_load(8, 2'd2);
    tick(); expect_q("sat_up1", 9, 0);
    tick(); expect_q("sat_up2", 9, 1);
    tick(); expect_q("sat_up3", 9, 1);
    do_load(1, 2'd3);
    tick(); expect_q("sat_dn1", 0, 0);
    tick(); expect_q("sat_dn2", 0, 1);
`endif

    // Out-of-range loads
    do_load(12, 2'd2);
    expect_q("load12", 12, 0);
    tick(); expect_q("up_over", 0, 0);
    do_load(13, 2'd3);
    tick(); expect_q("dn_over", 9, 0);

    // Priority: load beats wrap, en=0 holds
    do_load(8, 2'd2);
    tick(); expect_q("pri_9", 9, 0);
    load = 1'b1; load_val = 4'd5;
    tick(); expect_q("pri_load", 5, 0);
    load = 1'b0; en = 1'b0;
    tick(); expect_q("en_off", 5, 0);
    en = 1'b1; mode = 2'd0;
    tick(); expect_q("hold", 5, 0);

    // Mixed sweep, checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      t = 4'($urandom_range(0, 15));
      load = 1'($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      tick();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
